seg7_scan_driver: RTL

//   Time-multiplexed driver for the 4-digit common-anode 7-segment display. It sits

---
 rtl/seg7_scan_driver_if.sv | 33 +++
 rtl/seg7_scan_driver.sv | 133 +++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - control/pattern inputs and display outputs of the 7-segment scan driver
//
// Signals:
//   enable, load              scan enable and 1-cycle capture strobe
//   digit1..digit4 [6:0]      active-low segment patterns {g..a}, digit1 leftmost
//   dp_in [3:0]               active-low decimal points, [3]=digit1 .. [0]=digit4
//   seg_n [6:0], dp_n         shared segment bus and decimal point, active low
//   an_n [3:0]                anode enables, active low, [3]=digit1 .. [0]=digit4
//   frame_done                1-cycle pulse when the scan wraps to digit1
// Modports: master drives patterns/controls, slave is the display driver.
interface seg7_scan_driver_if;
  logic       enable;
  logic       load;
  logic [6:0] digit1;
  logic [6:0] digit2;
  logic [6:0] digit3;
  logic [6:0] digit4;
  logic [3:0] dp_in;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [3:0] an_n;
  logic       frame_done;

  modport master (
    output enable, load, digit1, digit2, digit3, digit4, dp_in,
    input  seg_n, dp_n, an_n, frame_done
  );

  modport slave (
    input  enable, load, digit1, digit2, digit3, digit4, dp_in,
    output seg_n, dp_n, an_n, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - double-buffered time-multiplexed 4-digit common-anode 7-segment driver
//
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   bus     seg7_scan_driver_if.slave (enable, load, digit1..4, dp_in -> seg_n, dp_n, an_n, frame_done)
// Parameters:
//   REFRESH_DIV   clk cycles per digit slot (>= 2)
//   GUARD_CYCLES  anode-off cycles at the end of each slot (< REFRESH_DIV)
// Configuration macro:
//   SEG7_GHOST_GUARD_EN  blank anodes/segments for the last GUARD_CYCLES of every slot;
//                        when undefined the anodes stay on for the whole slot.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST_CNT = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [1:0]    index;
  logic          tick;
  logic          boundary;

  logic [6:0]    pending   [4];
  logic [3:0]    pending_dp;
  logic          pending_valid;
  logic [6:0]    active    [4];
  logic [3:0]    active_dp;
  logic [6:0]    in_digit  [4];

  logic [6:0]    nxt_seg;
  logic          nxt_dp;
  logic [3:0]    nxt_an;

  always_comb begin
    in_digit[0] = bus.digit1;
    in_digit[1] = bus.digit2;
    in_digit[2] = bus.digit3;
    in_digit[3] = bus.digit4;
  end

  assign tick = (prescaler == LAST_CNT);
  // A prescaler left at its last count when enable drops must not count as a boundary.
  assign boundary = bus.enable && tick && (index == 2'd3);

  // Slot timing: held at digit1 / count 0 while disabled so re-enable starts a full slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      index     <= 2'd0;
    end else if (!bus.enable) begin
      prescaler <= '0;
      index     <= 2'd0;
    end else if (tick) begin
      prescaler <= '0;
      index     <= index + 2'd1;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // Double buffer: active only changes on a frame boundary so a frame never mixes
  // old and new digits. A load landing on the boundary itself bypasses pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        pending[i] <= 7'h7F;
        active[i]  <= 7'h7F;
      end
      pending_dp    <= 4'hF;
      active_dp     <= 4'hF;
      pending_valid <= 1'b0;
    end else begin
      if (boundary) begin
        if (bus.load) begin
          for (int i = 0; i < 4; i++) active[i] <= in_digit[i];
          active_dp <= bus.dp_in;
        end else if (pending_valid) begin
          for (int i = 0; i < 4; i++) active[i] <= pending[i];
          active_dp <= pending_dp;
        end
        pending_valid <= 1'b0;
      end else if (bus.load) begin
        for (int i = 0; i < 4; i++) pending[i] <= in_digit[i];
        pending_dp    <= bus.dp_in;
        pending_valid <= 1'b1;
      end
    end
  end

`ifdef SEG7_GHOST_GUARD_EN
  localparam logic [PW-1:0] GUARD_START = PW'(REFRESH_DIV - GUARD_CYCLES);
`endif

  always_comb begin
    nxt_seg = 7'h7F;
    nxt_dp  = 1'b1;
    nxt_an  = 4'hF;
    if (bus.enable) begin
      nxt_seg = active[index];
      nxt_dp  = active_dp[2'd3 - index];
      nxt_an  = ~(4'b1000 >> index);
`ifdef SEG7_GHOST_GUARD_EN
      // Dead time before the next digit; the decimal point follows its digit as usual.
      if (prescaler >= GUARD_START) begin
        nxt_an  = 4'hF;
        nxt_seg = 7'h7F;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg_n      <= 7'h7F;
      bus.dp_n       <= 1'b1;
      bus.an_n       <= 4'hF;
      bus.frame_done <= 1'b0;
    end else begin
      bus.seg_n      <= nxt_seg;
      bus.dp_n       <= nxt_dp;
      bus.an_n       <= nxt_an;
      bus.frame_done <= boundary;
    end
  end

endmodule
